aes128_key_expander: RTL and testbench

Iterative AES-128 key-expansion engine. It takes a 128-bit cipher key and produces the 11 round keys (round 0..10), one per cycle, under a valid/ready handshake. It instantiates one `g_function` (RotWord+SubWord via `sbox`) on the last word of the current round key, then XORs the round constant into the top byte. It sits directly downstream of `g_function` and upstream of the round datapath that consumes round keys.

---
 rtl/aes128_key_expander.sv | 138 +++++++++++++
 tb/tb_aes128_key_expander.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_key_expander.sv
// Iterative AES-128 key expansion: produces round keys 0..10, one per accepted
// valid/ready handshake, from a single g_function (RotWord+SubWord) on word 3.
module aes128_key_expander (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_EXPAND  = 1'b1;
    localparam logic [3:0] LAST_ROUND = 4'd10;

    logic [0:0]   state_r;
    logic [127:0] round_key_r;
    logic [3:0]   round_idx_r;
    logic [7:0]   rcon_r;
    logic         key_valid_r;

    logic         handshake_s;
    logic [31:0]  t_s;
    logic [31:0]  w0_s;
    logic [31:0]  w1_s;
    logic [31:0]  w2_s;
    logic [31:0]  w3_s;
    logic [7:0]   next_rcon_s;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] a_sh;
        p    = 8'h00;
        a_sh = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ a_sh;
            end else begin
                p = p;
            end
            if (a_sh[7]) begin
                a_sh = {a_sh[6:0], 1'b0} ^ 8'h1B;
            end else begin
                a_sh = {a_sh[6:0], 1'b0};
            end
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] g_function(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    // Next round key and round constant from the current registered state
    always_comb begin
        handshake_s = key_valid_r & key_ready;
        t_s  = g_function(round_key_r[31:0]) ^ {rcon_r, 24'h000000};
        w0_s = round_key_r[127:96] ^ t_s;
        w1_s = round_key_r[95:64]  ^ w0_s;
        w2_s = round_key_r[63:32]  ^ w1_s;
        w3_s = round_key_r[31:0]   ^ w2_s;
        if (rcon_r[7]) begin
            next_rcon_s = {rcon_r[6:0], 1'b0} ^ 8'h1B;
        end else begin
            next_rcon_s = {rcon_r[6:0], 1'b0};
        end
    end

    // Control FSM and round-key state; everything holds while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            round_key_r <= 128'h0;
            round_idx_r <= 4'd0;
            rcon_r      <= 8'h01;
            key_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r     <= ST_EXPAND;
                        round_key_r <= key_in;
                        round_idx_r <= 4'd0;
                        rcon_r      <= 8'h01;
                        key_valid_r <= 1'b1;
                    end
                end
                ST_EXPAND: begin
                    if (handshake_s) begin
                        if (round_idx_r == LAST_ROUND) begin
                            state_r     <= ST_IDLE;
                            key_valid_r <= 1'b0;
                        end else begin
                            round_key_r <= {w0_s, w1_s, w2_s, w3_s};
                            round_idx_r <= round_idx_r + 4'd1;
                            rcon_r      <= next_rcon_s;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    key_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign round_key = round_key_r;
    assign round_idx = round_idx_r;
    assign key_valid = key_valid_r;
    assign busy      = (state_r == ST_EXPAND);
    assign done      = key_valid_r & (round_idx_r == LAST_ROUND);

endmodule

// File: tb/tb_aes128_key_expander.sv
// Self-checking bench for aes128_key_expander: FIPS-197 key-schedule model plus
// a per-cycle compare process and hand-computed literal expectations.
module tb_aes128_key_expander;
    localparam logic [127:0] KEY_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_ZERO  = 128'h0;
    localparam logic [127:0] KEY_OTHER = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = 128'h0;
    logic         key_ready = 1'b1;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sb [0:255];
    logic [127:0] sched [0:2][0:10];

    logic         m_active = 1'b0;
    logic         m_zero = 1'b1;
    logic [3:0]   m_idx = 4'd0;
    int           m_sel = 0;

    aes128_key_expander dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .key_ready(key_ready),
        .round_key(round_key), .round_idx(round_idx), .key_valid(key_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // carry-less product then reduction by 0x11B
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] acc;
        acc = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) acc = acc ^ ({8'h00, a} << i);
        for (int i = 15; i >= 8; i--) if (acc[i]) acc = acc ^ (16'h011B << (i - 8));
        return acc[7:0];
    endfunction

    function automatic logic [7:0] sbox_model(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        inv = 8'h00;
        c = 8'h63;
        for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                 ^ inv[(i + 7) % 8] ^ c[i];
        return s;
    endfunction

    function automatic logic [127:0] model_rk(input logic [127:0] key, input int n);
        logic [31:0] w [0:43];
        logic [31:0] temp;
        logic [7:0]  rc [0:9];
        rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i - 1];
            if (i % 4 == 0)
                temp = {sb[temp[23:16]], sb[temp[15:8]], sb[temp[7:0]], sb[temp[31:24]]}
                     ^ {rc[i / 4 - 1], 24'h000000};
            w[i] = w[i - 4] ^ temp;
        end
        return {w[4 * n], w[4 * n + 1], w[4 * n + 2], w[4 * n + 3]};
    endfunction

    // transaction-level expectation: which key, which round, whether active
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_zero   <= 1'b1;
            m_idx    <= 4'd0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_zero   <= 1'b0;
                m_idx    <= 4'd0;
                m_sel    <= (key_in == KEY_FIPS) ? 0 : ((key_in == KEY_ZERO) ? 1 : 2);
            end
        end else if (key_ready) begin
            if (m_idx == 4'd10) m_active <= 1'b0;
            else m_idx <= m_idx + 4'd1;
        end
    end

    always @(negedge clk) begin
        chk("key_valid", {127'h0, key_valid}, {127'h0, m_active});
        chk("busy", {127'h0, busy}, {127'h0, m_active});
        chk("done", {127'h0, done}, {127'h0, m_active && (m_idx == 4'd10)});
        chk("round_idx", {124'h0, round_idx}, {124'h0, m_idx});
        chk("round_key", round_key, m_zero ? 128'h0 : sched[m_sel][m_idx]);
    end

    initial begin
        logic [3:0] pat;
        logic       finished;
        int         vcount;
        int         icount;
        pat = 4'b1001;

        for (int x = 0; x < 256; x++) sb[x] = sbox_model(8'(x));
        for (int k = 0; k < 3; k++)
            for (int n = 0; n < 11; n++)
                sched[k][n] = model_rk((k == 0) ? KEY_FIPS : ((k == 1) ? KEY_ZERO : KEY_OTHER), n);
        chk("model_sbox_00", {120'h0, sb[0]}, {120'h0, 8'h63});
        chk("model_sbox_53", {120'h0, sb[8'h53]}, {120'h0, 8'hed});
        chk("model_fips_r1", sched[0][1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("model_fips_r10", sched[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("model_zero_r1", sched[1][1], 128'h62636363626363636263636362636363);
        chk("model_zero_r10", sched[1][10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        chk("model_other_r10", sched[2][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", {127'h0, busy}, 128'h0);
        chk("reset_round_key", round_key, 128'h0);

        // FIPS key, key_ready held high
        key_in = KEY_FIPS; start = 1'b1; key_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("fips_r0_key", round_key, KEY_FIPS);
        chk("fips_r0_idx", {124'h0, round_idx}, 128'h0);
        @(negedge clk);
        chk("fips_r1_key", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
        repeat (9) @(negedge clk);
        chk("fips_done", {127'h0, done}, 128'h1);
        chk("fips_r10_key", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        @(negedge clk);
        chk("fips_busy_fall", {127'h0, busy}, 128'h0);
        chk("fips_hold_key", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // all-zero key exercises the rcon wrap
        @(negedge clk);
        key_in = KEY_ZERO; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("zero_r1_key", round_key, 128'h62636363626363636263636362636363);
        repeat (9) @(negedge clk);
        chk("zero_done", {127'h0, done}, 128'h1);
        chk("zero_r10_key", round_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // back-pressure: key_ready 1,0,0,1 then pseudo-random
        repeat (2) @(negedge clk);
        key_in = KEY_FIPS; start = 1'b1; key_ready = 1'b1;
        finished = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (!m_active) begin
                finished = 1'b1;
                break;
            end
            key_ready = (i < 4) ? pat[i] : 1'($urandom_range(0, 1));
        end
        chk("stall_terminates", {127'h0, finished}, 128'h1);
        key_ready = 1'b1;

        // start pulses during rounds 3 and 10 are ignored
        repeat (2) @(negedge clk);
        key_in = KEY_FIPS; start = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k == 12) chk("ignore_gap_valid", {127'h0, key_valid}, 128'h0);
            if (k == 13) chk("ignore_no_queue", {127'h0, key_valid}, 128'h0);
            start  = (k == 4) || (k == 11);
            key_in = start ? KEY_OTHER : KEY_FIPS;
        end
        start = 1'b0;

        // asynchronous reset in the middle of round 5
        @(negedge clk);
        key_in = KEY_FIPS; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_idx", {124'h0, round_idx}, 128'h5);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", {127'h0, key_valid}, 128'h0);
        chk("async_rst_busy", {127'h0, busy}, 128'h0);
        chk("async_rst_done", {127'h0, done}, 128'h0);
        chk("async_rst_idx", {124'h0, round_idx}, 128'h0);
        chk("async_rst_key", round_key, 128'h0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {127'h0, busy}, 128'h0);
        key_in = KEY_FIPS; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("post_rst_r0", round_key, KEY_FIPS);
        repeat (10) @(negedge clk);
        chk("post_rst_r10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // back-to-back: FIPS then zero key, start on the IDLE-return edge
        repeat (2) @(negedge clk);
        key_in = KEY_FIPS; start = 1'b1;
        vcount = 0; icount = 0;
        for (int k = 1; k <= 23; k++) begin
            @(negedge clk);
            if (key_valid) vcount++;
            else icount++;
            if (k == 12) chk("b2b_gap", {127'h0, key_valid}, 128'h0);
            if (k == 13) chk("b2b_second_r0", round_key, KEY_ZERO);
            start  = (k == 12);
            key_in = (k == 12) ? KEY_ZERO : KEY_FIPS;
        end
        chk("b2b_valid_count", 128'(vcount), 128'd22);
        chk("b2b_gap_count", 128'(icount), 128'd1);
        @(negedge clk);
        chk("b2b_end_idle", {127'h0, key_valid}, 128'h0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
